// File: rtl/twdl_pkg.sv
// Shared constants and types for the twiddle-stage sequencer.
//   W_NUM      : width of denominator, numerator, remainder and butterfly count
//   W_QUO      : quotient width and fixed-point shift (2^W_QUO)
//   twdl_st_e  : sequencer state encoding
//   FACTOR_MIN/FACTOR_MAX : legal radix range (2..5)
//   QUO_ONE    : 2^W_QUO, the dividend of the per-stage step division
package twdl_pkg;

  localparam int unsigned W_NUM = 12;
  localparam int unsigned W_QUO = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV_L = 2'd1,
    ST_DIV_Q = 2'd2,
    ST_RUN   = 2'd3
  } twdl_st_e;

  localparam logic [2:0] FACTOR_MIN = 3'd2;
  localparam logic [2:0] FACTOR_MAX = 3'd5;

  localparam logic [W_QUO:0] QUO_ONE = {1'b1, {W_QUO{1'b0}}};

  function automatic logic factor_legal(input logic [2:0] f);
    return (f >= FACTOR_MIN) && (f <= FACTOR_MAX);
  endfunction

endpackage

// File: rtl/seq_div_u20.sv
// Unsigned restoring divider, one quotient bit per cycle, W_QUO cycles per divide.
//   clk, rst_n : clock, async active-low reset
//   start      : load operands; the first quotient bit is produced on this edge
//   dividend   : W_QUO-bit dividend
//   dvd_msb    : extra dividend bit above dividend[W_QUO-1], preloaded into the
//                partial remainder; must be smaller than divisor so the quotient
//                still fits in W_QUO bits (lets 2^W_QUO be divided exactly)
//   divisor    : W_NUM-bit divisor, nonzero
//   busy       : iterations still in progress
//   done       : quotient/remainder valid (held until the next start)
//   quotient, remainder : results
module seq_div_u20
  import twdl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W_QUO-1:0] dividend,
  input  logic             dvd_msb,
  input  logic [W_NUM-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [W_QUO-1:0] quotient,
  output logic [W_NUM-1:0] remainder
);

  localparam logic [4:0] STEPS = 5'(W_QUO);

  logic [W_QUO-1:0] quo_q;
  logic [W_NUM-1:0] rem_q;
  logic [W_NUM-1:0] dvs_q;
  logic [4:0]       cnt_q;
  logic             run_q;

  logic [W_QUO-1:0] q_src, q_step;
  logic [W_NUM-1:0] r_src, d_src, r_step;
  logic [W_NUM:0]   trial, diff;
  logic             ge;

  // One restoring step; on start it operates on the fresh operands so the
  // divide completes after exactly W_QUO edges including the load edge.
  always_comb begin
    q_src  = start ? dividend : quo_q;
    r_src  = start ? {{(W_NUM-1){1'b0}}, dvd_msb} : rem_q;
    d_src  = start ? divisor : dvs_q;
    trial  = {r_src, q_src[W_QUO-1]};
    diff   = trial - {1'b0, d_src};
    ge     = (trial >= {1'b0, d_src});
    r_step = ge ? diff[W_NUM-1:0] : trial[W_NUM-1:0];
    q_step = {q_src[W_QUO-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      quo_q <= q_step;
      rem_q <= r_step;
      dvs_q <= divisor;
      cnt_q <= 5'd1;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q != STEPS) begin
        quo_q <= q_step;
        rem_q <= r_step;
        cnt_q <= cnt_q + 5'd1;
      end else begin
        run_q <= 1'b0;
      end
    end
  end

  assign busy      = run_q && (cnt_q != STEPS);
  assign done      = run_q && (cnt_q == STEPS);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/twdl_seq_ctrl.sv
// Sequencer for one mixed-radix twiddle stage.
//   clk, rst_n                 : clock, async active-low reset
//   cfg_start                  : configure-and-run request (honoured in IDLE only)
//   cfg_factor/demontr/nbfly/inverse : radix, span denominator D, butterfly count, direction
//   bfly_val / bfly_ready      : butterfly handshake (accept = val & ready)
//   factor, inverse, twdl_demontr : registered configuration
//   twdl_numrtr_1              : index n1 of the current butterfly
//   twdl_quotient/remainder    : floor(n1*2^W_QUO/D) and (n1*2^W_QUO) mod D
//   twdl_sop                   : first accepted butterfly of the frame
//   busy, done, cfg_err        : status; done/cfg_err are one-cycle pulses
module twdl_seq_ctrl
  import twdl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [2:0]       cfg_factor,
  input  logic [W_NUM-1:0] cfg_demontr,
  input  logic [W_NUM-1:0] cfg_nbfly,
  input  logic             cfg_inverse,
  input  logic             bfly_val,
  output logic             bfly_ready,
  output logic [2:0]       factor,
  output logic             inverse,
  output logic [W_NUM-1:0] twdl_demontr,
  output logic [W_NUM-1:0] twdl_numrtr_1,
  output logic [W_QUO-1:0] twdl_quotient,
  output logic [W_NUM-1:0] twdl_remainder,
  output logic             twdl_sop,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam logic [W_NUM-1:0] ONE_N = W_NUM'(1);
  localparam logic [W_QUO-1:0] ONE_Q = W_QUO'(1);

  twdl_st_e         state_q, state_d;
  logic [2:0]       factor_q, factor_d;
  logic             inverse_q, inverse_d;
  logic [W_NUM-1:0] dem_q, dem_d;
  logic [W_NUM-1:0] nbfly_q, nbfly_d;
  logic [W_NUM-1:0] len_q, len_d;
  logic [W_QUO-1:0] q0_q, q0_d;
  logic [W_NUM-1:0] r0_q, r0_d;
  logic [W_NUM-1:0] n1_q, n1_d;
  logic [W_QUO-1:0] quo_q, quo_d;
  logic [W_NUM-1:0] rem_q, rem_d;
  logic [W_NUM-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             div_start, div_msb, div_busy, div_done, div_fin;
  logic [W_QUO-1:0] div_dvd, div_quo;
  logic [W_NUM-1:0] div_dvs, div_rem;
  logic             accept, cfg_ok;
  logic [W_NUM:0]   r_sum, r_sub;

  seq_div_u20 u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (div_dvd),
    .dvd_msb   (div_msb),
    .divisor   (div_dvs),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign div_fin = div_done & ~div_busy;
  assign accept  = bfly_val & (state_q == ST_RUN);
  assign cfg_ok  = factor_legal(cfg_factor) && (cfg_demontr != '0) && (cfg_nbfly != '0);
  assign r_sum   = {1'b0, rem_q} + {1'b0, r0_q};
  assign r_sub   = r_sum - {1'b0, dem_q};

  always_comb begin
    state_d   = state_q;
    factor_d  = factor_q;
    inverse_d = inverse_q;
    dem_d     = dem_q;
    nbfly_d   = nbfly_q;
    len_d     = len_q;
    q0_d      = q0_q;
    r0_d      = r0_q;
    n1_d      = n1_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    div_start = 1'b0;
    div_dvd   = '0;
    div_msb   = 1'b0;
    div_dvs   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (!cfg_ok) begin
            err_d = 1'b1;
          end else begin
            factor_d  = cfg_factor;
            inverse_d = cfg_inverse;
            dem_d     = cfg_demontr;
            nbfly_d   = cfg_nbfly;
            if (cfg_demontr == ONE_N) begin
              len_d   = ONE_N;
              q0_d    = '0;
              r0_d    = '0;
              n1_d    = '0;
              quo_d   = '0;
              rem_d   = '0;
              cnt_d   = '0;
              state_d = ST_RUN;
            end else begin
              // L = D / factor is launched from the raw inputs so it overlaps the capture cycle.
              div_start = 1'b1;
              div_dvd   = {{(W_QUO-W_NUM){1'b0}}, cfg_demontr};
              div_dvs   = {{(W_NUM-3){1'b0}}, cfg_factor};
              state_d   = ST_DIV_L;
            end
          end
        end
      end
      ST_DIV_L: begin
        if (div_fin) begin
          if (div_rem != '0) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            len_d     = div_quo[W_NUM-1:0];
            div_start = 1'b1;
            div_dvd   = QUO_ONE[W_QUO-1:0];
            div_msb   = QUO_ONE[W_QUO];
            div_dvs   = dem_q;
            state_d   = ST_DIV_Q;
          end
        end
      end
      ST_DIV_Q: begin
        if (div_fin) begin
          q0_d    = div_quo;
          r0_d    = div_rem;
          n1_d    = '0;
          quo_d   = '0;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (n1_q == len_q - ONE_N) begin
            n1_d  = '0;
            quo_d = '0;
            rem_d = '0;
          end else begin
            n1_d = n1_q + ONE_N;
            if (r_sum >= {1'b0, dem_q}) begin
              rem_d = r_sub[W_NUM-1:0];
              quo_d = quo_q + q0_q + ONE_Q;
            end else begin
              rem_d = r_sum[W_NUM-1:0];
              quo_d = quo_q + q0_q;
            end
          end
          cnt_d = cnt_q + ONE_N;
          if (cnt_q == nbfly_q - ONE_N) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      factor_q  <= '0;
      inverse_q <= 1'b0;
      dem_q     <= '0;
      nbfly_q   <= '0;
      len_q     <= '0;
      q0_q      <= '0;
      r0_q      <= '0;
      n1_q      <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      factor_q  <= factor_d;
      inverse_q <= inverse_d;
      dem_q     <= dem_d;
      nbfly_q   <= nbfly_d;
      len_q     <= len_d;
      q0_q      <= q0_d;
      r0_q      <= r0_d;
      n1_q      <= n1_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bfly_ready     = (state_q == ST_RUN);
  assign twdl_sop       = accept & (cnt_q == '0);
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign cfg_err        = err_q;
  assign factor         = factor_q;
  assign inverse        = inverse_q;
  assign twdl_demontr   = dem_q;
  assign twdl_numrtr_1  = n1_q;
  assign twdl_quotient  = quo_q;
  assign twdl_remainder = rem_q;

endmodule

// File: tb/tb_twdl_seq_ctrl.sv
// Self-checking bench for twdl_seq_ctrl: table of configurations plus
// hand-written sequences for the multi-cycle corner cases.
module tb_twdl_seq_ctrl;
  import twdl_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cfg_start = 1'b0;
  logic [2:0]       cfg_factor = '0;
  logic [W_NUM-1:0] cfg_demontr = '0;
  logic [W_NUM-1:0] cfg_nbfly = '0;
  logic             cfg_inverse = 1'b0;
  logic             bfly_val = 1'b0;
  logic             bfly_ready;
  logic [2:0]       factor;
  logic             inverse;
  logic [W_NUM-1:0] twdl_demontr;
  logic [W_NUM-1:0] twdl_numrtr_1;
  logic [W_QUO-1:0] twdl_quotient;
  logic [W_NUM-1:0] twdl_remainder;
  logic             twdl_sop;
  logic             busy;
  logic             done;
  logic             cfg_err;

  twdl_seq_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_start      (cfg_start),
    .cfg_factor     (cfg_factor),
    .cfg_demontr    (cfg_demontr),
    .cfg_nbfly      (cfg_nbfly),
    .cfg_inverse    (cfg_inverse),
    .bfly_val       (bfly_val),
    .bfly_ready     (bfly_ready),
    .factor         (factor),
    .inverse        (inverse),
    .twdl_demontr   (twdl_demontr),
    .twdl_numrtr_1  (twdl_numrtr_1),
    .twdl_quotient  (twdl_quotient),
    .twdl_remainder (twdl_remainder),
    .twdl_sop       (twdl_sop),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int f;
    int d;
    int n;
    int err_at;
    int rdy_at;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(bfly_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(cfg_err), 0);
    chk({tag, "_sop"}, 32'(twdl_sop), 0);
    chk({tag, "_factor"}, 32'(factor), 0);
    chk({tag, "_inverse"}, 32'(inverse), 0);
    chk({tag, "_dem"}, 32'(twdl_demontr), 0);
    chk({tag, "_n1"}, 32'(twdl_numrtr_1), 0);
    chk({tag, "_quo"}, 32'(twdl_quotient), 0);
    chk({tag, "_rem"}, 32'(twdl_remainder), 0);
  endtask

  // Issue a configuration, report the first cfg_err / bfly_ready cycle
  // (relative to the cfg_start cycle), then drain the frame with bfly_val high.
  task automatic run_cfg(input int f, input int d, input int n,
                         output int err_at, output int rdy_at, output int busy1,
                         output int acc, output int got_done);
    err_at = 0; rdy_at = 0; busy1 = 0; acc = 0; got_done = 0;
    adv();
    cfg_factor  = 3'(f);
    cfg_demontr = W_NUM'(d);
    cfg_nbfly   = W_NUM'(n);
    cfg_inverse = 1'b0;
    cfg_start   = 1'b1;
    bfly_val    = 1'b0;
    adv();
    cfg_start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      mid();
      if (c == 1) busy1 = int'(busy);
      if (cfg_err && err_at == 0) err_at = c;
      if (bfly_ready) begin
        rdy_at = c;
        break;
      end
      if (err_at != 0 && c >= err_at + 2) break;
      adv();
    end
    if (rdy_at != 0) begin
      bfly_val = 1'b1;
      for (int k = 0; k < n + 4; k++) begin
        if (bfly_ready) acc++;
        adv();
        if (done) begin
          got_done = 1;
          break;
        end
        mid();
      end
      bfly_val = 1'b0;
    end
  endtask

  initial begin
    int err_at, rdy_at, busy1, acc, got_done;
    int rdy, idx, dn, seen, m;
    int exp_n[4];
    int exp_q[4];
    int exp_r[4];
    longint gq, gr;

    vecs[0] = '{3, 12, 8, 0, 41};
    vecs[1] = '{5, 1, 3, 0, 1};
    vecs[2] = '{6, 12, 8, 1, 0};
    vecs[3] = '{3, 0, 4, 1, 0};
    vecs[4] = '{3, 12, 0, 1, 0};
    vecs[5] = '{3, 10, 4, 21, 0};
    vecs[6] = '{1, 4, 2, 1, 0};
    vecs[7] = '{4, 20, 5, 0, 41};
    vecs[8] = '{2, 2, 1, 0, 41};
    exp_n = '{0, 1, 2, 3};
    exp_q = '{0, 87381, 174762, 262144};
    exp_r = '{0, 4, 8, 0};

    // Reset state
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    adv(); adv();
    mid();
    rst_n = 1'b1;

    // Table-driven configurations
    foreach (vecs[v]) begin
      run_cfg(vecs[v].f, vecs[v].d, vecs[v].n, err_at, rdy_at, busy1, acc, got_done);
      chk("vec_err_at", err_at, vecs[v].err_at);
      chk("vec_rdy_at", rdy_at, vecs[v].rdy_at);
      if (vecs[v].rdy_at != 0) begin
        chk("vec_accepts", acc, vecs[v].n);
        chk("vec_done", got_done, 1);
      end
      if (vecs[v].err_at == 1) chk("vec_busy_static_err", busy1, 0);
    end

    // D=12 factor=3 nbfly=8, bfly_val held high; cfg_start reasserted mid-frame
    adv();
    cfg_factor = 3'd3; cfg_demontr = 12'd12; cfg_nbfly = 12'd8; cfg_inverse = 1'b1;
    cfg_start = 1'b1; bfly_val = 1'b1;
    rdy = 0; idx = 0; dn = 0;
    for (int c = 1; c <= 60; c++) begin
      adv();
      cfg_start = 1'b0;
      if (done) begin
        chk("seq_done_cycle", c, 49);
        dn = 1;
        break;
      end
      mid();
      if (bfly_ready) begin
        if (rdy == 0) rdy = c;
        chk("seq_n1", 32'(twdl_numrtr_1), exp_n[idx % 4]);
        chk("seq_quo", 32'(twdl_quotient), exp_q[idx % 4]);
        chk("seq_rem", 32'(twdl_remainder), exp_r[idx % 4]);
        chk("seq_sop", 32'(twdl_sop), (idx == 0) ? 1 : 0);
        idx++;
        if (idx == 4) begin
          cfg_start = 1'b1; cfg_factor = 3'd5; cfg_demontr = 12'd1; cfg_nbfly = 12'd3;
        end
      end
    end
    chk("seq_ready_at", rdy, 41);
    chk("seq_done_seen", dn, 1);
    chk("seq_accepts", idx, 8);
    chk("seq_factor_held", 32'(factor), 3);
    chk("seq_dem_held", 32'(twdl_demontr), 12);
    chk("seq_inverse_held", 32'(inverse), 1);

    // Back-to-back start in the done cycle: D=1 factor=5 nbfly=3
    cfg_factor = 3'd5; cfg_demontr = 12'd1; cfg_nbfly = 12'd3; cfg_inverse = 1'b0;
    cfg_start = 1'b1; bfly_val = 1'b0;
    adv();
    cfg_start = 1'b0;
    mid();
    chk("b2b_ready", 32'(bfly_ready), 1);
    chk("b2b_factor", 32'(factor), 5);
    bfly_val = 1'b1;
    acc = 0; got_done = 0;
    for (int k = 0; k < 8; k++) begin
      if (bfly_ready) begin
        acc++;
        chk("b2b_n1", 32'(twdl_numrtr_1), 0);
        chk("b2b_quo", 32'(twdl_quotient), 0);
        chk("b2b_rem", 32'(twdl_remainder), 0);
      end
      adv();
      if (done) begin
        got_done = 1;
        break;
      end
      mid();
    end
    bfly_val = 1'b0;
    chk("b2b_accepts", acc, 3);
    chk("b2b_done", got_done, 1);

    // Random bfly_val in RUN, D=20 factor=4 (L=5), against golden n1*2^20/D
    adv();
    cfg_factor = 3'd4; cfg_demontr = 12'd20; cfg_nbfly = 12'd12;
    cfg_start = 1'b1;
    adv();
    cfg_start = 1'b0;
    rdy = 0;
    for (int c = 1; c <= 45 && rdy == 0; c++) begin
      mid();
      if (bfly_ready) rdy = c;
      else adv();
    end
    chk("rnd_ready_at", rdy, 41);
    adv();
    m = 0;
    for (int c = 0; c < 200; c++) begin
      bfly_val = 1'($urandom_range(1, 0));
      mid();
      gq = (longint'(m % 5) << 20) / 20;
      gr = (longint'(m % 5) << 20) % 20;
      chk("rnd_ready", 32'(bfly_ready), 1);
      chk("rnd_n1", 32'(twdl_numrtr_1), m % 5);
      chk("rnd_quo", 32'(twdl_quotient), 32'(gq));
      chk("rnd_rem", 32'(twdl_remainder), 32'(gr));
      chk("rnd_sop", 32'(twdl_sop), (bfly_val && m == 0) ? 1 : 0);
      if (bfly_val) m++;
      adv();
      if (m == 12) break;
    end
    chk("rnd_accepts", m, 12);
    chk("rnd_done", 32'(done), 1);
    bfly_val = 1'b0;

    // Reset during DIV_Q
    adv();
    cfg_factor = 3'd3; cfg_demontr = 12'd12; cfg_nbfly = 12'd8;
    cfg_start = 1'b1;
    adv();
    cfg_start = 1'b0;
    repeat (29) adv();
    mid();
    chk("divq_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1 chk_zero("rst_divq");
    adv(); adv();
    mid();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 45; k++) begin
      adv();
      if (done || busy) seen = 1;
    end
    chk("rst_divq_quiet", seen, 0);
    run_cfg(3, 12, 4, err_at, rdy_at, busy1, acc, got_done);
    chk("after_divq_rdy", rdy_at, 41);
    chk("after_divq_acc", acc, 4);
    chk("after_divq_done", got_done, 1);

    // Reset mid-RUN after three accepts
    adv();
    cfg_factor = 3'd4; cfg_demontr = 12'd20; cfg_nbfly = 12'd10;
    cfg_start = 1'b1;
    adv();
    cfg_start = 1'b0;
    rdy = 0;
    for (int c = 1; c <= 45 && rdy == 0; c++) begin
      mid();
      if (bfly_ready) rdy = c;
      else adv();
    end
    chk("run_rst_ready_at", rdy, 41);
    bfly_val = 1'b1;
    repeat (3) adv();
    mid();
    chk("run_rst_n1_before", 32'(twdl_numrtr_1), 3);
    chk("run_rst_quo_before", 32'(twdl_quotient), 157286);
    chk("run_rst_rem_before", 32'(twdl_remainder), 8);
    rst_n = 1'b0;
    #1 chk_zero("rst_run");
    bfly_val = 1'b0;
    adv(); adv();
    mid();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      adv();
      if (done) seen = 1;
    end
    chk("rst_run_no_done", seen, 0);
    run_cfg(5, 1, 3, err_at, rdy_at, busy1, acc, got_done);
    chk("after_run_rdy", rdy_at, 1);
    chk("after_run_acc", acc, 3);
    chk("after_run_done", got_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/twdl_seq_ctrl.md
# twdl_seq_ctrl

Sequencer for one mixed-radix twiddle stage. It accepts a per-stage configuration: radix factor, span denominator, butterfly count and direction. For every accepted butterfly it produces the twiddle-generator parameters: numerator index, denominator, quotient and remainder of index·2^20/denominator, frame SOP and direction. It sits between the stage controller/address FIFO and the twiddle multiply stage, driving that stage's `factor`, `twdl_*` and `inverse` inputs.

## Interface
- `W_NUM`, 12: width of denominator, numerator, remainder and butterfly count.
- `W_QUO`, 20: quotient width; also the fixed-point shift (2^W_QUO).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_start`  in  1  one-cycle configure-and-run request.
- `cfg_factor`  in  3  radix; legal values are 2, 3, 4, 5.
- `cfg_demontr`  in  W_NUM  span denominator D, with D ≥ 1.
- `cfg_nbfly`  in  W_NUM  butterflies in the frame, with nbfly ≥ 1.
- `cfg_inverse`  in  1  0 = FFT, 1 = IFFT.
- `bfly_val`  in  1  upstream offers one butterfly.
- `bfly_ready`  out  1  controller can accept a butterfly.
- `factor`  out  3  registered cfg_factor.
- `inverse`  out  1  registered cfg_inverse.
- `twdl_demontr`  out  W_NUM  registered D.
- `twdl_numrtr_1`  out  W_NUM  current index n1.
- `twdl_quotient`  out  W_QUO  floor(n1·2^20/D).
- `twdl_remainder`  out  W_NUM  (n1·2^20) mod D.
- `twdl_sop`  out  1  first accepted butterfly of the frame.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse after the last butterfly is accepted.
- `cfg_err`  out  1  one-cycle pulse when a configuration is rejected.

## Operation
- States are IDLE, DIV_L, DIV_Q and RUN.
- **IDLE, on `cfg_start`:**
  - Register all cfg inputs.
  - If factor ∉ {2,3,4,5}, or D = 0, or nbfly = 0: pulse `cfg_err` and stay in IDLE.
  - If D = 1: set L = 1, q0 = 0, r0 = 0 and go to RUN.
  - Otherwise go to DIV_L.
- **DIV_L:** compute L = D / factor with the shared divider.
  - If the remainder ≠ 0: pulse `cfg_err` and go to IDLE.
  - Otherwise go to DIV_Q.
- **DIV_Q:** compute q0 = 2^20 / D and r0 = 2^20 mod D. Clear n1, q, r and the butterfly counter, then go to RUN.
- **RUN:** `bfly_ready` = 1. An accept is `bfly_val & bfly_ready`. On each accept:
  - `twdl_sop` = accept & (counter = 0).
  - r' = r + r0, computed 13 bits wide.
  - If r' ≥ D: r ← r' − D and q ← q + q0 + 1. Otherwise r ← r' and q ← q + q0.
  - n1 ← n1 + 1.
  - Wrap: when n1 = L−1, then n1, q and r all return to 0 instead.
  - On the accept where counter = nbfly−1: pulse `done` the next cycle and go to IDLE.
- Range guarantees: n1 < L ≤ D/2 keeps q < 2^19, and r < D always.
- `cfg_start` outside IDLE is ignored; no queueing.
- `factor`, `inverse` and `twdl_demontr` hold their values after a frame until the next legal `cfg_start`.

## Timing
- Reset value of every output and all state is 0, so after reset the state is IDLE.
- Reset asserted mid-operation aborts at once: outputs go to 0 and state to IDLE, with no `done`.
- Parameter outputs are registers. The values present in the cycle of an accept belong to that butterfly, and the next values appear the following cycle. Zero-latency pairing with `bfly_val`.
- `twdl_sop` and `bfly_ready` are combinational from state, counter and `bfly_val`.
- Divider: one cycle per quotient bit, 20 cycles per divide.
- Start-to-ready latency:
  - With D > 1, `bfly_ready` first rises 41 cycles after the `cfg_start` cycle: 1 capture, 20 for DIV_L, 20 for DIV_Q.
  - With D = 1 it rises after 1 cycle.
- `cfg_err` pulses 1 cycle after `cfg_start` for static errors, and 21 cycles after it for a nonzero DIV_L remainder.
- The next `cfg_start` is accepted in the cycle after `done`, with no bubble beyond that one cycle.

## Structure
- Package `twdl_pkg`:
  - `W_NUM`, `W_QUO`
  - the state enum `twdl_st_e`
  - the legal-factor constants and the 2^W_QUO dividend constant.
- Sub-module `seq_div_u20`: unsigned restoring divider with a 20-bit dividend and 12-bit divisor. Ports: `start`, `busy`, `done`, quotient, remainder. It is shared by DIV_L and DIV_Q.
- The top level holds the FSM, counters, q/r accumulator and output registers.

## Test plan
- D=12, factor=3, nbfly=8, bval held high:
  - `bfly_ready` rises at +41.
  - (n1, q, r) sequence is (0,0,0) (1,87381,4) (2,174762,8) (3,262144,0), then repeats.
  - `twdl_sop` only on the first accept; `done` one cycle after the 8th.
- D=1, factor=5, nbfly=3: ready at +1; n1, q and r stay 0; `done` after 3 accepts.
- Illegal configs:
  - factor=6, or D=0, or nbfly=0 → `cfg_err` at +1, `busy` stays 0.
  - D=10, factor=3 → `cfg_err` at +21.
- `bfly_val` toggled randomly in RUN with D=20, factor=4: outputs advance only on accepts, checked against a golden model of n1·2^20 / D.
- `rst_n` pulsed low in DIV_Q and in mid-RUN: all outputs go to 0 immediately, with no `done`. A following `cfg_start` runs correctly.
- `cfg_start` reasserted during RUN is ignored and the frame completes unchanged. Back-to-back frames (start in the cycle after `done`) are accepted.
